// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing generator and the pixel pipeline.
// The master side (vga_timing) drives every signal; pixel generators and the
// connector logic attach to the slave side.
interface vga_timing_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       valid;
  logic       hsync;
  logic       vsync;
  logic       newframe;
  logic       line_end;
  logic [7:0] frame;
  logic       pix_en;

  modport master (
    output x, y, valid, hsync, vsync, newframe, line_end, frame, pix_en
  );

  modport slave (
    input x, y, valid, hsync, vsync, newframe, line_end, frame, pix_en
  );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator (640x480@60 by default).
// Owns the horizontal/vertical counters and registers every output from the
// next-counter values, so coordinates, syncs and strobes never skew.
// Optional macro VGA_CLKDIV_EN: adds CLK_DIV and an internal divider so the
// block runs from a fast clk, advancing one slot per pix_en strobe.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
`ifdef VGA_CLKDIV_EN
  , parameter int CLK_DIV = 4
`endif
) (
  input logic clk,
  input logic rst,
  vga_timing_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] x_q, y_q, x_nxt, y_nxt;
  logic       valid_q, hs_q, vs_q, nf_q, le_q;
  logic [7:0] frame_q;
  logic       nf_nxt;
  logic       step;

`ifdef VGA_CLKDIV_EN
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_nxt;
  logic          pe_q;

  // divider wrap; a slot begins on the edge where the divider reaches its last count
  always_comb begin
    div_nxt = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
  end

  assign step = (div_nxt == DIV_LAST);

  // divider and registered pixel strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      pe_q  <= 1'b0;
    end else begin
      div_q <= div_nxt;
      pe_q  <= step;
    end
  end

  assign vif.pix_en = pe_q;
`else
  assign step       = 1'b1;
  assign vif.pix_en = 1'b1;
`endif

  // next raster position; totals compared explicitly so any parameter set wraps cleanly
  always_comb begin
    x_nxt = x_q + 10'd1;
    y_nxt = y_q;
    if (x_q == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
    nf_nxt = (x_nxt == '0) && (y_nxt == V_ACT);
  end

  // all outputs registered from the next position so they stay mutually aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b1;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      nf_q    <= 1'b0;
      le_q    <= 1'b0;
      frame_q <= '0;
    end else if (step) begin
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      valid_q <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
      hs_q    <= ((x_nxt >= HS_BEG) && (x_nxt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_q    <= ((y_nxt >= VS_BEG) && (y_nxt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
      nf_q    <= nf_nxt;
      le_q    <= (x_nxt == H_LAST);
      if (nf_nxt) frame_q <= frame_q + 8'd1;
    end else begin
      // strobes last a single clk even when slots span several clks
      nf_q <= 1'b0;
      le_q <= 1'b0;
    end
  end

  assign vif.x        = x_q;
  assign vif.y        = y_q;
  assign vif.valid    = valid_q;
  assign vif.hsync    = hs_q;
  assign vif.vsync    = vs_q;
  assign vif.newframe = nf_q;
  assign vif.line_end = le_q;
  assign vif.frame    = frame_q;

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing: a full-size raster instance for line-level
// checks and a scaled-down raster instance (24x12 totals) for frame-level
// checks, frame wrap and mid-frame reset. Expected values are hand-computed
// vectors queued up front; a monitor pops and compares them at their slot.
module tb_vga_timing;

  localparam int END_IDX = 73970;

  localparam int F_X = 0, F_Y = 1, F_VALID = 2, F_HS = 3, F_VS = 4, F_NF = 5,
                 F_LE = 6, F_FR = 7, F_PE = 8;
  localparam int A_HSLOW = 10, A_LE = 11, A_VSLOW = 12, A_NF = 13, A_PERR = 14;

  typedef struct {
    int idx;
    int inst;
    int fld;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic rst_s = 1'b1;
  bit   running = 1'b0;
  bit   mon_done = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t sbq[$];

  int hslow_b = 0, le_b = 0, vslow_s = 0, nf_s = 0, perr_s = 0, last_nf = -1;

  vga_timing_if vif_b ();
  vga_timing_if vif_s ();

  vga_timing u_big (
    .clk (clk),
    .rst (rst_b),
    .vif (vif_b)
  );

  vga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0)
  ) u_small (
    .clk (clk),
    .rst (rst_s),
    .vif (vif_s)
  );

  always #5 clk = ~clk;

  function automatic int getv(input int inst, input int fld);
    int v;
    v = -1;
    if (inst == 0) begin
      case (fld)
        F_X:     v = int'(vif_b.x);
        F_Y:     v = int'(vif_b.y);
        F_VALID: v = int'(vif_b.valid);
        F_HS:    v = int'(vif_b.hsync);
        F_VS:    v = int'(vif_b.vsync);
        F_NF:    v = int'(vif_b.newframe);
        F_LE:    v = int'(vif_b.line_end);
        F_FR:    v = int'(vif_b.frame);
        F_PE:    v = int'(vif_b.pix_en);
        A_HSLOW: v = hslow_b;
        A_LE:    v = le_b;
        default: v = -1;
      endcase
    end else begin
      case (fld)
        F_X:     v = int'(vif_s.x);
        F_Y:     v = int'(vif_s.y);
        F_VALID: v = int'(vif_s.valid);
        F_HS:    v = int'(vif_s.hsync);
        F_VS:    v = int'(vif_s.vsync);
        F_NF:    v = int'(vif_s.newframe);
        F_LE:    v = int'(vif_s.line_end);
        F_FR:    v = int'(vif_s.frame);
        F_PE:    v = int'(vif_s.pix_en);
        A_VSLOW: v = vslow_s;
        A_NF:    v = nf_s;
        A_PERR:  v = perr_s;
        default: v = -1;
      endcase
    end
    return v;
  endfunction

  function automatic string fname(input int fld);
    case (fld)
      F_X: return "x";        F_Y: return "y";       F_VALID: return "valid";
      F_HS: return "hsync";   F_VS: return "vsync";  F_NF: return "newframe";
      F_LE: return "line_end"; F_FR: return "frame"; F_PE: return "pix_en";
      A_HSLOW: return "hsync_low_slots_line0";
      A_LE: return "line_end_count_line0";
      A_VSLOW: return "vsync_low_slots_frame0";
      A_NF: return "newframe_count";
      A_PERR: return "newframe_period_errors";
      default: return "unknown";
    endcase
  endfunction

  task automatic push(input int idx, input int inst, input int fld, input int val);
    exp_t e;
    e.idx = idx; e.inst = inst; e.fld = fld; e.val = val;
    sbq.push_back(e);
  endtask

  task automatic push_all(input int idx, input int inst, input int xv, input int yv,
                          input int va, input int hs, input int vs, input int nf,
                          input int le, input int fr);
    push(idx, inst, F_X, xv);   push(idx, inst, F_Y, yv);
    push(idx, inst, F_VALID, va);
    push(idx, inst, F_HS, hs);  push(idx, inst, F_VS, vs);
    push(idx, inst, F_NF, nf);  push(idx, inst, F_LE, le);
    push(idx, inst, F_FR, fr);  push(idx, inst, F_PE, 1);
  endtask

  task automatic process(input int idx);
    exp_t e;
    int   act;
    while (sbq.size() > 0 && sbq[0].idx <= idx) begin
      e = sbq.pop_front();
      n_cmp++;
      act = getv(e.inst, e.fld);
      if (e.idx != idx || act != e.val) begin
        n_bad++;
        $display("FAIL %s inst=%0d slot=%0d (at %0d): got %0d expected %0d",
                 fname(e.fld), e.inst, e.idx, idx, act, e.val);
      end
    end
    if (idx < 800) begin
      if (vif_b.hsync == 1'b0) hslow_b++;
      if (vif_b.line_end) le_b++;
    end
    if (idx < 288 && vif_s.vsync == 1'b0) vslow_s++;
    if (idx < 73900 && vif_s.newframe) begin
      nf_s++;
      if (last_nf >= 0 && idx - last_nf != 288) perr_s++;
      last_nf = idx;
    end
  endtask

  // monitor: slot 0 is the reset state seen at release, then one slot per clk
  initial begin
    wait (running);
    process(0);
    for (int i = 1; i <= END_IDX; i++) begin
      @(posedge clk);
      #1;
      process(i);
    end
    mon_done = 1'b1;
  end

  // stimulus: queue the directed expectations, release reset, pulse small-raster reset mid-frame
  initial begin
    push_all(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    push_all(0, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    push(16, 1, F_VALID, 0);
    push(17, 1, F_HS, 1);
    push(18, 1, F_HS, 0);
    push(21, 1, F_HS, 0);
    push(22, 1, F_HS, 1);
    push(23, 1, F_LE, 1);
    push(24, 1, F_X, 0); push(24, 1, F_Y, 1); push(24, 1, F_VALID, 1); push(24, 1, F_LE, 0);
    push(143, 1, F_NF, 0); push(143, 1, F_FR, 0); push(143, 1, F_X, 23); push(143, 1, F_Y, 5);
    push(144, 1, F_NF, 1); push(144, 1, F_FR, 1); push(144, 1, F_X, 0); push(144, 1, F_Y, 6);
    push(144, 1, F_VALID, 0);
    push(145, 1, F_NF, 0); push(145, 1, F_FR, 1);
    push(191, 1, F_VS, 1);
    push(192, 1, F_VS, 0);
    push(239, 1, F_VS, 0);
    push(240, 1, F_VS, 1);
    push(288, 1, A_VSLOW, 48); push(288, 1, A_NF, 1);
    push(288, 1, F_X, 0); push(288, 1, F_Y, 0); push(288, 1, F_VALID, 1); push(288, 1, F_FR, 1);
    push(639, 0, F_X, 639); push(639, 0, F_VALID, 1);
    push(640, 0, F_VALID, 0);
    push(655, 0, F_HS, 1);
    push(656, 0, F_HS, 0);
    push(751, 0, F_HS, 0);
    push(752, 0, F_HS, 1);
    push(798, 0, F_LE, 0);
    push(799, 0, F_X, 799); push(799, 0, F_Y, 0); push(799, 0, F_LE, 1);
    push(800, 0, F_X, 0); push(800, 0, F_Y, 1); push(800, 0, F_VALID, 1); push(800, 0, F_LE, 0);
    push(800, 0, A_HSLOW, 96); push(800, 0, A_LE, 1);
    push(1456, 0, F_HS, 0);
    push(73296, 1, F_FR, 255); push(73296, 1, F_NF, 1);
    push(73584, 1, F_FR, 0); push(73584, 1, F_NF, 1);
    push(73585, 1, A_NF, 256);
    push(73900, 1, A_PERR, 0);
    push(73964, 1, F_X, 20); push(73964, 1, F_Y, 9); push(73964, 1, F_HS, 0);
    push(73964, 1, F_VS, 0); push(73964, 1, F_VALID, 0); push(73964, 1, F_FR, 1);
    push_all(73965, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    push(73966, 1, F_X, 1); push(73966, 1, F_Y, 0);
    push(73966, 0, F_X, 366); push(73966, 0, F_Y, 92);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    rst_s = 1'b0;
    running = 1'b1;
    repeat (73964) @(posedge clk);
    @(negedge clk);
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;

    fork
      wait (mon_done);
      begin
        repeat (END_IDX + 200) @(posedge clk);
      end
    join_any
    disable fork;
    if (!mon_done) begin
      n_bad++;
      $display("FAIL monitor_timeout: got not_done expected done");
    end
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_bad++;
      $display("FAIL unchecked_%s slot=%0d: got none expected %0d", fname(e.fld), e.idx, e.val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
